// File: rtl/clock_phase_monitor_pkg.sv
// clock_phase_monitor_pkg
// Shared types and constants for the Slipstream clock phase monitor:
//   - chan_state_e : per-channel lock FSM states
//   - period multipliers (in MCK periods) for each monitored clock
//   - channel index map and the period-counter timeout value
//   - per_cycles() : multiplier * MCK_DIV as an 8-bit MasterClock count
package clock_phase_monitor_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_MEASURE = 2'd1,
        CH_LOCKED  = 2'd2
    } chan_state_e;

    localparam int NUM_CHAN = 4;

    // Channel slots; the two active-low inputs sit in the upper half.
    localparam int CH_CCLK   = 0;
    localparam int CH_DQCLK  = 1;
    localparam int CH_PCLK   = 2;
    localparam int CH_CHROMA = 3;

    localparam int PER_CCLK_MULT = 3;
    localparam int PER_PCLK_FAST = 2;
    localparam int PER_PCLK_SLOW = 3;
    localparam int PER_PAL       = 4;
    localparam int PER_NTSC      = 5;

    localparam logic [7:0] TIMEOUT = 8'd255;

    function automatic logic [7:0] per_cycles(input int mult, input int div);
        return 8'(mult * div);
    endfunction

endpackage

// File: rtl/clk_chan_check.sv
// clk_chan_check
// One monitored clock: edge detector, 8-bit period counter and lock FSM.
// Ports:
//   clk        in   MasterClock
//   RSTL       in   synchronous active-low reset
//   din        in   raw clock under check
//   inv        in   1 = active-low input (detect falling edge)
//   expected   in   expected period in MasterClock cycles
//   restart    in   mode change: back to MEASURE, edge in this cycle ignored
//   edge_pulse out  registered one-cycle edge enable
//   locked     out  FSM is in LOCKED
//   error      out  combinational error decision for this cycle
module clk_chan_check
    import clock_phase_monitor_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       RSTL,
    input  logic       din,
    input  logic       inv,
    input  logic [7:0] expected,
    input  logic       restart,
    output logic       edge_pulse,
    output logic       locked,
    output logic       error
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    logic        s, p, edge_det, good, timeout;
    logic [7:0]  cnt;
    logic [3:0]  match, match_n;
    chan_state_e state, state_n;

    assign edge_det = inv ? (~s & p) : (s & ~p);
    assign good     = (cnt == expected);
    // The counter never holds 255: the increment that would reach it is the
    // timeout, so a stuck clock errors every 255 cycles.
    assign timeout  = (cnt == TIMEOUT - 8'd1) && !edge_det;
    assign locked   = (state == CH_LOCKED);

    always_ff @(posedge clk) begin
        if (!RSTL) begin
            s          <= 1'b0;
            p          <= 1'b0;
            edge_pulse <= 1'b0;
            cnt        <= '0;
            state      <= CH_IDLE;
            match      <= '0;
        end else begin
            s          <= din;
            p          <= s;
            edge_pulse <= edge_det;
            if (edge_det)     cnt <= 8'd1;
            else if (timeout) cnt <= '0;
            else              cnt <= cnt + 8'd1;
            state      <= state_n;
            match      <= match_n;
        end
    end

    // Timeout beats a mode restart, which beats an edge comparison.
    always_comb begin
        state_n = state;
        match_n = match;
        error   = 1'b0;
        if (timeout) begin
            state_n = CH_IDLE;
            match_n = '0;
            error   = 1'b1;
        end else if (restart) begin
            state_n = CH_MEASURE;
            match_n = '0;
        end else if (edge_det) begin
            unique case (state)
                CH_IDLE: state_n = CH_MEASURE;
                CH_MEASURE: begin
                    if (good) begin
                        match_n = match + 4'd1;
                        if (match_n == LOCK_N) state_n = CH_LOCKED;
                    end else begin
                        error   = 1'b1;
                        match_n = '0;
                    end
                end
                CH_LOCKED: begin
                    if (!good) begin
                        error   = 1'b1;
                        state_n = CH_MEASURE;
                        match_n = '0;
                    end
                end
                default: state_n = CH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/clock_phase_monitor.sv
// clock_phase_monitor
// Samples the Slipstream derived clocks on MasterClock, turns their active
// edges into one-cycle enables and checks every period against the mode.
// Ports:
//   MasterClock              in   sole clock
//   RSTL                     in   synchronous active-low reset
//   CCLK, DQCLK              in   active-high clocks under check
//   PCLKL, CHROMAL           in   active-low clocks under check
//   NTSC, FAST               in   mode straps
//   CCLK_RISE .. CHROMA_RISE out  one-cycle edge enables
//   LOCKED                   out  all four channels locked (registered)
//   ERR                      out  sticky error flag
//   ERRCNT                   out  error-cycle count, saturating at 255
module clock_phase_monitor
    import clock_phase_monitor_pkg::*;
#(
    parameter int MCK_DIV    = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic       MasterClock,
    input  logic       RSTL,
    input  logic       CCLK,
    input  logic       DQCLK,
    input  logic       PCLKL,
    input  logic       CHROMAL,
    input  logic       NTSC,
    input  logic       FAST,
    output logic       CCLK_RISE,
    output logic       DQCLK_RISE,
    output logic       PCLK_RISE,
    output logic       CHROMA_RISE,
    output logic       LOCKED,
    output logic       ERR,
    output logic [7:0] ERRCNT
);

    localparam logic [7:0] EXP_CCLK   = per_cycles(PER_CCLK_MULT, MCK_DIV);
    localparam logic [7:0] EXP_P_FAST = per_cycles(PER_PCLK_FAST, MCK_DIV);
    localparam logic [7:0] EXP_P_SLOW = per_cycles(PER_PCLK_SLOW, MCK_DIV);
    localparam logic [7:0] EXP_NTSC   = per_cycles(PER_NTSC, MCK_DIV);
    localparam logic [7:0] EXP_PAL    = per_cycles(PER_PAL, MCK_DIV);

    logic [NUM_CHAN-1:0]      raw, inv, restart, rise, chan_lock, chan_err;
    logic [NUM_CHAN-1:0][7:0] expected;
    logic                     ntsc_r, fast_r, mode_vld;

    assign raw = {CHROMAL, PCLKL, DQCLK, CCLK};
    assign inv = 4'b1100;

    // mode_vld masks the first cycle after reset so straps that come up
    // nonzero do not look like a mode change.
    assign restart[CH_CCLK]   = 1'b0;
    assign restart[CH_DQCLK]  = 1'b0;
    assign restart[CH_PCLK]   = mode_vld & (FAST ^ fast_r);
    assign restart[CH_CHROMA] = mode_vld & (NTSC ^ ntsc_r);

    assign expected[CH_CCLK]   = EXP_CCLK;
    assign expected[CH_DQCLK]  = EXP_CCLK;
    assign expected[CH_PCLK]   = fast_r ? EXP_P_FAST : EXP_P_SLOW;
    assign expected[CH_CHROMA] = ntsc_r ? EXP_NTSC : EXP_PAL;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        clk_chan_check #(.LOCK_COUNT(LOCK_COUNT)) u_chk (
            .clk        (MasterClock),
            .RSTL       (RSTL),
            .din        (raw[i]),
            .inv        (inv[i]),
            .expected   (expected[i]),
            .restart    (restart[i]),
            .edge_pulse (rise[i]),
            .locked     (chan_lock[i]),
            .error      (chan_err[i])
        );
    end

    assign CCLK_RISE   = rise[CH_CCLK];
    assign DQCLK_RISE  = rise[CH_DQCLK];
    assign PCLK_RISE   = rise[CH_PCLK];
    assign CHROMA_RISE = rise[CH_CHROMA];

    always_ff @(posedge MasterClock) begin
        if (!RSTL) begin
            ntsc_r   <= 1'b0;
            fast_r   <= 1'b0;
            mode_vld <= 1'b0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            ERRCNT   <= '0;
        end else begin
            ntsc_r   <= NTSC;
            fast_r   <= FAST;
            mode_vld <= 1'b1;
            LOCKED   <= &chan_lock;
            // Several channels failing together still count once.
            if (|chan_err) begin
                ERR <= 1'b1;
                if (ERRCNT != 8'hFF) ERRCNT <= ERRCNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_phase_monitor.sv
// tb_clock_phase_monitor
// Directed bench: per-channel clock generators drive the DUT, every active
// input edge pushes its expected RISE cycle into a per-channel queue, and
// the RISE outputs are checked against the queues every cycle. Lock, error
// and counter behaviour are checked at computed cycle offsets.
module tb_clock_phase_monitor;

    logic       MasterClock = 1'b0;
    logic       RSTL = 1'b0;
    logic [3:0] clk_in = 4'b0000;
    logic       NTSC = 1'b0, FAST = 1'b0;
    logic       CCLK_RISE, DQCLK_RISE, PCLK_RISE, CHROMA_RISE, LOCKED, ERR;
    logic [7:0] ERRCNT;
    logic [3:0] rise_v;

    always #5 MasterClock = ~MasterClock;

    clock_phase_monitor #(.MCK_DIV(2), .LOCK_COUNT(4)) dut (
        .MasterClock (MasterClock),
        .RSTL        (RSTL),
        .CCLK        (clk_in[0]),
        .DQCLK       (clk_in[1]),
        .PCLKL       (clk_in[2]),
        .CHROMAL     (clk_in[3]),
        .NTSC        (NTSC),
        .FAST        (FAST),
        .CCLK_RISE   (CCLK_RISE),
        .DQCLK_RISE  (DQCLK_RISE),
        .PCLK_RISE   (PCLK_RISE),
        .CHROMA_RISE (CHROMA_RISE),
        .LOCKED      (LOCKED),
        .ERR         (ERR),
        .ERRCNT      (ERRCNT)
    );

    assign rise_v = {CHROMA_RISE, PCLK_RISE, DQCLK_RISE, CCLK_RISE};

    int nvec = 0, nerr = 0, cyc = 0;
    int per[4], ph[4];
    bit stuck[4], edge_seen[4];
    bit hold = 0, sb_en = 0;
    int sbq[4][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Channels 0/1 are active-high, 2/3 active-low.
    task automatic set_pin(input int ch, input bit act);
        clk_in[ch] = (ch < 2) ? act : ~act;
    endtask

    // Active edge at ph==0; an input driven after edge c is first sampled at
    // c+1, so its RISE is expected after edge c+2.
    task automatic drive_gen();
        for (int i = 0; i < 4; i++) begin
            edge_seen[i] = 0;
            if (hold || stuck[i]) begin
                set_pin(i, 1'b0);
            end else begin
                ph[i]++;
                if (ph[i] >= per[i]) ph[i] = 0;
                if (ph[i] == 0) begin
                    edge_seen[i] = 1;
                    if (sb_en) sbq[i].push_back(cyc + 2);
                end
                set_pin(i, ph[i] < per[i] / 2);
            end
        end
    endtask

    task automatic tick();
        logic e;
        @(posedge MasterClock);
        cyc++;
        #1;
        drive_gen();
        @(negedge MasterClock);
        if (sb_en) begin
            for (int i = 0; i < 4; i++) begin
                e = (sbq[i].size() > 0) && (sbq[i][0] == cyc);
                if (e) void'(sbq[i].pop_front());
                chk($sformatf("rise_ch%0d@%0d", i, cyc), 32'(rise_v[i]), 32'(e));
            end
        end
    endtask

    task automatic run_until_edge(input int ch);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!edge_seen[ch] && n < 400);
        chk("edge_wait", 32'(edge_seen[ch]), 1);
    endtask

    task automatic wait_locked(input int budget);
        int n = 0;
        while (LOCKED !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("lock_wait", 32'(LOCKED), 1);
    endtask

    // Inputs keep toggling during reset; at release they are parked at their
    // inactive level for one cycle, then all generators restart in phase.
    task automatic do_reset(input int n);
        sb_en = 0;
        for (int i = 0; i < 4; i++) sbq[i].delete();
        RSTL = 1'b0;
        repeat (n) tick();
        chk("rst_rise", 32'(rise_v), 0);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_errcnt", 32'(ERRCNT), 0);
        RSTL = 1'b1;
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            ph[i] = -1;
            set_pin(i, 1'b0);
        end
        sb_en = 1;
        tick();
        hold = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d, n;
        logic [7:0] e0;
        per = '{6, 6, 6, 8};
        ph  = '{0, 0, 0, 0};
        stuck = '{0, 0, 0, 0};

        // Reset with inputs toggling, then PAL slow lock-in.
        do_reset(4);
        c0 = cyc + 1;
        wait_locked(100);
        chk("lock_time", cyc - c0, 35);
        chk("lock_err", 32'(ERR), 0);
        chk("lock_errcnt", 32'(ERRCNT), 0);

        // One CCLK period stretched to 9.
        run_until_edge(0);
        per[0] = 9;
        run_until_edge(0);
        per[0] = 6;
        tick();
        tick();
        d = cyc;
        chk("stretch_err", 32'(ERR), 1);
        chk("stretch_cnt", 32'(ERRCNT), 1);
        chk("stretch_lock_lag", 32'(LOCKED), 1);
        tick();
        chk("stretch_unlock", 32'(LOCKED), 0);
        wait_locked(100);
        chk("stretch_relock", cyc - d, 25);

        // NTSC 0->1 landing in the same cycle as a chroma edge decision.
        run_until_edge(3);
        per[3] = 10;
        tick();
        NTSC = 1'b1;
        tick();
        d = cyc;
        chk("ntsc_lock_lag", 32'(LOCKED), 1);
        tick();
        chk("ntsc_unlock", 32'(LOCKED), 0);
        wait_locked(100);
        chk("ntsc_relock", cyc - d, 41);
        chk("ntsc_errcnt", 32'(ERRCNT), 1);

        // Six DQCLK periods of 2 (toggling every cycle) -> six errors.
        run_until_edge(1);
        per[1] = 2;
        repeat (6) run_until_edge(1);
        per[1] = 6;
        d = cyc;
        wait_locked(100);
        chk("dq_errcnt", 32'(ERRCNT), 7);
        chk("dq_relock", cyc - d, 27);

        // One-cycle reset while locked with ERRCNT=7, then relock (NTSC).
        do_reset(1);
        c0 = cyc + 1;
        wait_locked(100);
        chk("rst_relock", cyc - c0, 43);
        chk("rst_relock_err", 32'(ERR), 0);
        chk("rst_relock_cnt", 32'(ERRCNT), 0);

        // DQCLK stuck low: first timeout 256 cycles after its last edge
        // drive, then one every 255 cycles.
        run_until_edge(1);
        stuck[1] = 1;
        d = cyc;
        e0 = ERRCNT;
        n = 0;
        while (ERRCNT == e0 && n < 300) begin
            tick();
            n++;
        end
        chk("to_first", cyc - d, 256);
        chk("to_cnt1", 32'(ERRCNT), 1);
        chk("to_err", 32'(ERR), 1);
        d = cyc;
        tick();
        chk("to_unlock", 32'(LOCKED), 0);
        e0 = ERRCNT;
        n = 0;
        while (ERRCNT == e0 && n < 300) begin
            tick();
            n++;
        end
        chk("to_interval", cyc - d, 255);
        chk("to_cnt2", 32'(ERRCNT), 2);

        // Fast DQCLK toggling drives ERRCNT into saturation.
        stuck[1] = 0;
        ph[1] = -1;
        per[1] = 2;
        n = 0;
        while (ERRCNT !== 8'd255 && n < 700) begin
            tick();
            n++;
        end
        chk("sat_reach", 32'(ERRCNT), 255);
        chk("sat_err", 32'(ERR), 1);
        repeat (30) tick();
        chk("sat_hold", 32'(ERRCNT), 255);
        chk("sat_unlocked", 32'(LOCKED), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/clock_phase_monitor.md
# clock_phase_monitor

Checker and edge recoverer for the Slipstream clock outputs (CCLK, DQCLK, PCLKL, CHROMAL). It samples these on MasterClock and emits one-cycle rising-edge enables, so the downstream CPU, DSP and video models run off MasterClock enables instead of derived clocks. It measures every period against the value the current NTSC/FAST mode implies, reports lock, and counts timing errors. It sits directly after the clock generator in the simulation top.

## Interface
- MCK_DIV, 2: MasterClock cycles per MCK period.
- LOCK_COUNT, 4: consecutive good periods a channel needs before it locks; range 1..15.
- MasterClock  in  1  sole clock; all state updates on the rising edge.
- RSTL  in  1  reset, synchronous, active-low.
- CCLK, DQCLK  in  1 each  active-high clocks under check.
- PCLKL, CHROMAL  in  1 each  active-low clocks; the monitor detects the falling edges of these inputs.
- NTSC, FAST  in  1 each  mode straps, same meaning as at the clock generator.
- CCLK_RISE, DQCLK_RISE, PCLK_RISE, CHROMA_RISE  out  1 each  one-cycle edge enables.
- LOCKED  out  1  all four channels locked.
- ERR  out  1  sticky; set by any channel error.
- ERRCNT  out  8  error count, saturates at 255.

## Operation
- Expected periods in MasterClock cycles:
  - CCLK and DQCLK: 3·MCK_DIV.
  - PCLK: FAST ? 2·MCK_DIV : 3·MCK_DIV.
  - CHROMA: NTSC ? 5·MCK_DIV : 4·MCK_DIV.
  - With the defaults: 6, 6, 4/6, 10/8.
- Per-channel front end:
  - Input register s, previous register p.
  - Edge = s & ~p for the active-high inputs, ~s & p for the active-low inputs.
  - The RISE output is the registered edge.
- Per-channel period counter, 8 bits:
  - Loads 1 on an edge, otherwise increments.
  - On reaching 255 it raises a timeout and loads 0.
- Per-channel FSM with states IDLE, MEASURE, LOCKED and a 4-bit match counter:
  - IDLE: the first edge moves to MEASURE. No comparison is made for that edge.
  - MEASURE: an edge with counter == expected increments the match counter. When it reaches LOCK_COUNT, go to LOCKED.
  - MEASURE: an edge with counter != expected is an error; clear the match counter and stay in MEASURE.
  - LOCKED: a good edge keeps LOCKED. A bad edge is an error; go to MEASURE with the match counter cleared.
  - Any state: a timeout is an error (IDLE included, if a clock is stuck since reset) and moves the channel to IDLE.
- Mode change:
  - NTSC and FAST are registered.
  - A change in NTSC forces the CHROMA channel to MEASURE with the match counter cleared and the period counter unchanged. This does not count as an error.
  - A change in FAST does the same to the PCLK channel.
  - If a mode change and an edge occur in the same cycle, the mode change wins and the edge is not compared.
- LOCKED = AND of the four channel LOCKED states, registered.
- ERRCNT increments by 1 in any cycle in which one or more channels errors, never by more than 1. It holds at 255.
- ERR is set on the first error and cleared only by reset.

## Timing
- Reset (RSTL low at a rising edge) puts everything in its reset state at that edge:
  - Outputs: all RISE outputs 0, LOCKED 0, ERR 0, ERRCNT 0.
  - Channel state: IDLE with all counters 0; s and p are 0.
  - This applies mid-operation as well: nothing persists.
- Edge latency:
  - An input first sampled at its new level at edge k gives a RISE output high from edge k+1 to edge k+2, exactly one cycle.
  - A steady clock produces a RISE output exactly once per period.
- The error decision is made at the edge-detect cycle. ERR, ERRCNT and the channel state reflect it one cycle later, in the same cycle as the RISE output.
- LOCKED lags the last channel reaching LOCKED by one cycle.
- LOCKED drops one cycle after any channel leaves LOCKED.
- The minimum accepted period is 2, so an input toggling every cycle is counted as errors, not as missed edges.

## Structure
- A shared package holds:
  - the channel state enum;
  - constants PER_CCLK_MULT = 3, PER_PCLK_FAST = 2, PER_PCLK_SLOW = 3, PER_PAL = 4, PER_NTSC = 5;
  - the timeout value 255.
- Sub-module clk_chan_check: edge detect, period counter, FSM. Ports: clock, RSTL, raw input, invert select, expected[7:0], mode-change restart.
  - Outputs: edge pulse, locked, error.
  - Instantiated four times.
- The top level holds the mode registers, the expected-period mux, the LOCKED AND, and the ERR/ERRCNT logic.

## Test plan
- Reset: hold RSTL low with the inputs toggling → all outputs 0. Release → no RISE output until the second sampled edge of an input.
- Ideal PAL slow stimulus (CCLK/DQCLK/PCLKL period 6, CHROMAL period 8) → LOCKED rises one cycle after the 5th CHROMA edge (cycle 34 after the first CHROMA edge); ERR=0; CCLK_RISE once every 6 cycles.
- Stretch a single CCLK period to 9 while locked → ERR=1, ERRCNT=1, LOCKED low. It re-asserts after 4 good CCLK periods (24 cycles).
- Switch NTSC 0→1 while locked, with CHROMAL moving to period 10 → LOCKED drops for 4 chroma periods then returns; ERRCNT unchanged.
- Hold DQCLK low indefinitely → an error every 255 cycles; ERRCNT climbs and saturates at 255 after 255 timeouts, then holds.
- Assert RSTL low for one cycle while locked with ERRCNT=7 → next cycle LOCKED=0, ERR=0, ERRCNT=0, then normal relock.
